// File: rtl/rng_arbiter_pkg.sv
// Shared definitions for the RNG arbiter: default widths, requester
// indices, FSM state encoding and a pointer-width helper.
package rng_arbiter_pkg;

   localparam int RNG_W_DEF  = 96;
   localparam int NREQ_DEF   = 3;

   // Requester slots on the arbiter
   localparam int REQ_KGEN   = 0;
   localparam int REQ_CGEN   = 1;
   localparam int REQ_RESEED = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_DELIVER = 2'd3
   } state_t;

   // Round-robin pointer width; never zero so NREQ=1 still elaborates
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rng_arbiter_if.sv
// Bundle between the key-generation controllers / RNG core and the arbiter.
//
// Handshake: a requester holds req[i] (with its seed_mode/lock/seed stable)
// until it sees ack[i]; ack is a single-cycle completion pulse and rdata is
// valid only in that cycle. Towards the RNG, rng_start is a single-cycle
// pulse qualified by rng_in_mod/rng_seed; the RNG answers with one
// rng_finish pulse carrying rng_data. There is no back-pressure on either
// side beyond the arbiter's own serialisation.
interface rng_arbiter_if
   import rng_arbiter_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int RNG_W = RNG_W_DEF
) ();

   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       req_seed_mode;
   logic [NREQ-1:0]       req_lock;
   logic [NREQ*RNG_W-1:0] req_seed;
   logic [NREQ-1:0]       grant;
   logic [NREQ-1:0]       ack;
   logic [RNG_W-1:0]      rdata;
   logic                  tmo_err;
   logic                  busy;
   logic                  rng_start;
   logic                  rng_in_mod;
   logic [RNG_W-1:0]      rng_seed;
   logic [RNG_W-1:0]      rng_data;
   logic                  rng_finish;

   // Environment side: requesters plus the RNG core
   modport master (
      output req, req_seed_mode, req_lock, req_seed, rng_data, rng_finish,
      input  grant, ack, rdata, tmo_err, busy, rng_start, rng_in_mod, rng_seed
   );

   // Arbiter side
   modport slave (
      input  req, req_seed_mode, req_lock, req_seed, rng_data, rng_finish,
      output grant, ack, rdata, tmo_err, busy, rng_start, rng_in_mod, rng_seed
   );

endinterface

// File: rtl/rng_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping, returned one-hot together with a found flag.
module rr_pick
   import rng_arbiter_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int PW   = ptr_width(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_pick,
   output logic            o_found
);

   // Scan offsets 0..NREQ-1 from the pointer; first hit wins
   always_comb begin
      o_pick  = '0;
      o_found = 1'b0;
      for (int off = 0; off < NREQ; off++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!o_found && (i == ((int'(i_ptr) + off) % NREQ)) && i_req[i]) begin
               o_pick[i] = 1'b1;
               o_found   = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/rng_arbiter.sv
// Owns the RNG control port and serialises draw / seed-load requests from
// the generation controllers with round-robin fairness, locked bursts and
// a watchdog that abandons draws the RNG never finishes.
module rng_arbiter
   import rng_arbiter_pkg::*;
#(
   parameter  int NREQ  = NREQ_DEF,
   parameter  int RNG_W = RNG_W_DEF,
   parameter  int TMO   = 1023,
   localparam int PW    = ptr_width(NREQ),
   localparam int CW    = $clog2(TMO + 1)
) (
   input  logic      clk,
   input  logic      rst_b,
   rng_arbiter_if.slave bus,
   output state_t    o_state,
   output logic [PW-1:0] o_ptr
);

   state_t             r_state;
   logic [PW-1:0]      r_ptr;
   logic [PW-1:0]      r_gidx;
   logic [NREQ-1:0]    r_grant;
   logic [NREQ-1:0]    r_ack;
   logic [RNG_W-1:0]   r_rdata;
   logic               r_tmo_err;
   logic               r_busy;
   logic               r_rng_start;
   logic               r_rng_in_mod;
   logic [RNG_W-1:0]   r_rng_seed;
   logic [CW-1:0]      r_cnt;

   logic [NREQ-1:0]    w_pick;
   logic               w_found;
   logic [PW-1:0]      w_pick_idx;
   logic [PW-1:0]      w_issue_idx;
   logic               w_issue_mode;
   logic [RNG_W-1:0]   w_issue_seed;
   logic [PW-1:0]      w_next_ptr;
   logic               w_keep;

   rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .i_req   (bus.req),
      .i_ptr   (r_ptr),
      .o_pick  (w_pick),
      .o_found (w_found)
   );

   // One-hot pick to binary index
   always_comb begin
      w_pick_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_pick[i]) w_pick_idx = PW'(i);
      end
   end

   // Mode and seed of the requester about to be issued (new pick or burst owner)
   always_comb begin
      w_issue_idx  = (r_state == ST_IDLE) ? w_pick_idx : r_gidx;
      w_issue_mode = 1'b0;
      w_issue_seed = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (PW'(i) == w_issue_idx) begin
            w_issue_mode = bus.req_seed_mode[i];
            w_issue_seed = bus.req_seed[i*RNG_W +: RNG_W];
         end
      end
      if (!w_issue_mode) w_issue_seed = '0;
   end

   // Burst continuation test and pointer advance past the current owner
   always_comb begin
      w_keep = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (PW'(i) == r_gidx) w_keep = bus.req_lock[i] && bus.req[i];
      end
      w_next_ptr = (int'(r_gidx) >= NREQ - 1) ? '0 : r_gidx + PW'(1);
   end

   // Arbitration FSM; every output is a register set on the transition
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state      <= ST_IDLE;
         r_ptr        <= '0;
         r_gidx       <= '0;
         r_grant      <= '0;
         r_ack        <= '0;
         r_rdata      <= '0;
         r_tmo_err    <= 1'b0;
         r_busy       <= 1'b0;
         r_rng_start  <= 1'b0;
         r_rng_in_mod <= 1'b0;
         r_rng_seed   <= '0;
         r_cnt        <= '0;
      end else begin
         r_ack        <= '0;
         r_rng_start  <= 1'b0;
         r_rng_in_mod <= 1'b0;
         r_rng_seed   <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_grant      <= w_pick;
                  r_gidx       <= w_pick_idx;
                  r_busy       <= 1'b1;
                  r_rng_start  <= 1'b1;
                  r_rng_in_mod <= w_issue_mode;
                  r_rng_seed   <= w_issue_seed;
                  r_state      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // rng_finish seen here belongs to nobody and is dropped
               r_cnt   <= '0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (bus.rng_finish) begin
                  r_rdata <= bus.rng_data;
                  r_ack   <= r_grant;
                  r_state <= ST_DELIVER;
               end else if (r_cnt == CW'(TMO)) begin
                  r_tmo_err <= 1'b1;
                  r_grant   <= '0;
                  r_busy    <= 1'b0;
                  r_ptr     <= w_next_ptr;
                  r_state   <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_DELIVER: begin
               if (w_keep) begin
                  r_rng_start  <= 1'b1;
                  r_rng_in_mod <= w_issue_mode;
                  r_rng_seed   <= w_issue_seed;
                  r_state      <= ST_ISSUE;
               end else begin
                  r_grant <= '0;
                  r_busy  <= 1'b0;
                  r_ptr   <= w_next_ptr;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.grant      = r_grant;
   assign bus.ack        = r_ack;
   assign bus.rdata      = r_rdata;
   assign bus.tmo_err    = r_tmo_err;
   assign bus.busy       = r_busy;
   assign bus.rng_start  = r_rng_start;
   assign bus.rng_in_mod = r_rng_in_mod;
   assign bus.rng_seed   = r_rng_seed;
   assign o_state        = r_state;
   assign o_ptr          = r_ptr;

endmodule
